// File: rtl/lpc_record_serializer_if.sv
// lpc_record_serializer_if: record input, byte output and status signals of the serializer.
interface lpc_record_serializer_if #(
    parameter int AW = 48,
    parameter int DEPTH_LOG2 = 2
);
    logic [AW-1:0]         in_data;
    logic                  in_valid;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DEPTH_LOG2:0]   fifo_level;
    logic                  overflow;
    logic [7:0]            dropped;
    logic                  clear_overflow;
    modport master (
        output in_data, in_valid, tx_ready, clear_overflow,
        input  tx_data, tx_valid, fifo_level, overflow, dropped
    );
    modport slave (
        input  in_data, in_valid, tx_ready, clear_overflow,
        output tx_data, tx_valid, fifo_level, overflow, dropped
    );
endinterface

// File: rtl/lpc_record_serializer.sv
// lpc_record_serializer: queues record strobes in a small FIFO and streams each as SYNC plus MSB-first bytes.
module lpc_record_serializer #(
    parameter int AW = 48,
    parameter int DEPTH_LOG2 = 2,
    parameter logic [7:0] SYNC = 8'hA5
) (
    input logic clock,
    input logic reset,
    lpc_record_serializer_if.slave bus
);
    localparam int NB = AW / 8;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int LW = DEPTH_LOG2 + 1;
    localparam int IW = NB > 1 ? $clog2(NB) : 1;
    typedef enum logic [1:0] {IDLE, SEND_SYNC, SEND_DATA} state_t;
    state_t                state_q, state_d;
    logic [AW-1:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]         level_q, level_d;
    logic [AW-1:0]         shift_q, shift_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            dropped_q, dropped_d;
    logic                  xfer, last, pop, push, drop;
    always_comb begin
        xfer = tx_valid_q && bus.tx_ready;
        last = (state_q == SEND_DATA) && (idx_q == IW'(NB - 1));
        // A pop frees a slot at the same edge, so a full FIFO still takes the push
        pop  = (level_q != '0) && ((state_q == IDLE) || (xfer && last));
        push = bus.in_valid && ((level_q < LW'(DEPTH)) || pop);
        drop = bus.in_valid && !push;
        wr_d = wr_q + DEPTH_LOG2'(push);
        rd_d = rd_q + DEPTH_LOG2'(pop);
        level_d = level_q + LW'(push) - LW'(pop);
        overflow_d = bus.clear_overflow ? 1'b0 : (drop ? 1'b1 : overflow_q);
        dropped_d = bus.clear_overflow ? {7'b0, drop} :
                    ((drop && dropped_q != 8'hFF) ? dropped_q + 8'd1 : dropped_q);
        state_d = state_q;
        shift_d = shift_q;
        idx_d = idx_q;
        tx_data_d = tx_data_q;
        tx_valid_d = tx_valid_q;
        if (pop) begin
            shift_d = mem_q[rd_q];
            tx_data_d = SYNC;
            tx_valid_d = 1'b1;
            idx_d = '0;
            state_d = SEND_SYNC;
        end else if (xfer) begin
            if (last) begin
                tx_valid_d = 1'b0;
                state_d = IDLE;
            end else begin
                tx_data_d = shift_q[AW-1 -: 8];
                shift_d = shift_q << 8;
                idx_d = (state_q == SEND_SYNC) ? '0 : idx_q + IW'(1);
                state_d = SEND_DATA;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            wr_q <= '0;
            rd_q <= '0;
            level_q <= '0;
            shift_q <= '0;
            idx_q <= '0;
            tx_data_q <= '0;
            tx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            dropped_q <= '0;
        end else begin
            if (push) mem_q[wr_q] <= bus.in_data;
            state_q <= state_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            level_q <= level_d;
            shift_q <= shift_d;
            idx_q <= idx_d;
            tx_data_q <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overflow_q <= overflow_d;
            dropped_q <= dropped_d;
        end
    end
    assign bus.tx_data = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.fifo_level = level_q;
    assign bus.overflow = overflow_q;
    assign bus.dropped = dropped_q;
endmodule

// File: tb/tb_lpc_record_serializer.sv
// tb_lpc_record_serializer: directed checks of framing, backpressure, overflow and reset behaviour.
module tb_lpc_record_serializer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int cyc;
    lpc_record_serializer_if #(.AW(48), .DEPTH_LOG2(2)) bus ();
    lpc_record_serializer #(.AW(48), .DEPTH_LOG2(2), .SYNC(8'hA5)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );
    always #5 clock = ~clock;
    task automatic tick;
        @(posedge clock);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // Receives one framed record; stall=1 drives tx_ready 1,0,0 repeating
    task automatic recv(input logic [47:0] rec, input bit stall, output int n);
        int idx;
        logic [7:0] exp;
        logic v, r;
        idx = 0;
        n = 0;
        while (idx < 7 && n < 64) begin
            exp = (idx == 0) ? 8'hA5 : 8'(rec >> (8 * (6 - idx)));
            if (!stall) chk("contiguous_valid", 64'(bus.tx_valid), 64'd1);
            if (bus.tx_valid) chk("byte", 64'(bus.tx_data), 64'(exp));
            bus.tx_ready = stall ? (n % 3 == 0) : 1'b1;
            v = bus.tx_valid;
            r = bus.tx_ready;
            tick();
            n++;
            if (v && r) idx++;
        end
        chk("record_complete", 64'(idx), 64'd7);
    endtask
    initial begin
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.tx_ready = 1'b0;
        bus.clear_overflow = 1'b0;
        repeat (3) tick();
        chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("rst_tx_data", 64'(bus.tx_data), 64'd0);
        chk("rst_level", 64'(bus.fifo_level), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        chk("rst_dropped", 64'(bus.dropped), 64'd0);
        reset = 1'b0;
        tick();
        // single record
        bus.in_data = 48'h112233445566;
        bus.in_valid = 1'b1;
        bus.tx_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("single_lag_valid", 64'(bus.tx_valid), 64'd0);
        chk("single_lag_level", 64'(bus.fifo_level), 64'd1);
        tick();
        recv(48'h112233445566, 1'b0, cyc);
        chk("single_cycles", 64'(cyc), 64'd7);
        chk("single_end_valid", 64'(bus.tx_valid), 64'd0);
        chk("single_end_level", 64'(bus.fifo_level), 64'd0);
        // backpressure
        bus.in_data = 48'h112233445566;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        recv(48'h112233445566, 1'b1, cyc);
        chk("bp_cycles", 64'(cyc), 64'd19);
        chk("bp_end_valid", 64'(bus.tx_valid), 64'd0);
        // back-to-back
        bus.tx_ready = 1'b1;
        bus.in_data = 48'hAAAAAAAAAAAA;
        bus.in_valid = 1'b1;
        tick();
        chk("b2b_level_a", 64'(bus.fifo_level), 64'd1);
        bus.in_data = 48'h000000000001;
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_level_b", 64'(bus.fifo_level), 64'd1);
        recv(48'hAAAAAAAAAAAA, 1'b0, cyc);
        chk("b2b_level_c", 64'(bus.fifo_level), 64'd0);
        recv(48'h000000000001, 1'b0, cyc);
        chk("b2b_end_valid", 64'(bus.tx_valid), 64'd0);
        // overflow: six pulses against a stalled transmitter
        bus.tx_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.in_data = 48'hC0FFEE000010 + 48'(k);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("ovf_level", 64'(bus.fifo_level), 64'd4);
        chk("ovf_flag", 64'(bus.overflow), 64'd1);
        chk("ovf_dropped", 64'(bus.dropped), 64'd1);
        chk("ovf_head", 64'(bus.tx_data), 64'hA5);
        bus.in_data = 48'hDEADDEADDEAD;
        bus.in_valid = 1'b1;
        bus.clear_overflow = 1'b1;
        tick();
        bus.clear_overflow = 1'b0;
        chk("clr_drop_flag", 64'(bus.overflow), 64'd0);
        chk("clr_drop_count", 64'(bus.dropped), 64'd1);
        repeat (256) tick();
        bus.in_valid = 1'b0;
        chk("sat_dropped", 64'(bus.dropped), 64'd255);
        chk("sat_flag", 64'(bus.overflow), 64'd1);
        bus.clear_overflow = 1'b1;
        tick();
        bus.clear_overflow = 1'b0;
        chk("clr_flag", 64'(bus.overflow), 64'd0);
        chk("clr_dropped", 64'(bus.dropped), 64'd0);
        chk("clr_level", 64'(bus.fifo_level), 64'd4);
        // full FIFO: push lands on the edge whose final-byte transfer pops
        bus.tx_ready = 1'b1;
        repeat (6) tick();
        chk("full_last_byte", 64'(bus.tx_data), 64'h10);
        chk("full_level_pre", 64'(bus.fifo_level), 64'd4);
        bus.in_data = 48'h0BADC0FFEE99;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("full_level_post", 64'(bus.fifo_level), 64'd4);
        chk("full_overflow", 64'(bus.overflow), 64'd0);
        chk("full_dropped", 64'(bus.dropped), 64'd0);
        for (int k = 1; k < 5; k++) recv(48'hC0FFEE000010 + 48'(k), 1'b0, cyc);
        recv(48'h0BADC0FFEE99, 1'b0, cyc);
        chk("full_end_valid", 64'(bus.tx_valid), 64'd0);
        chk("full_end_level", 64'(bus.fifo_level), 64'd0);
        // reset in the middle of a record with another one queued
        bus.in_data = 48'h123456789ABC;
        bus.in_valid = 1'b1;
        tick();
        bus.in_data = 48'h222222222222;
        tick();
        bus.in_valid = 1'b0;
        chk("mid_head", 64'(bus.tx_data), 64'hA5);
        repeat (3) tick();
        chk("mid_third", 64'(bus.tx_data), 64'h56);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", 64'(bus.tx_valid), 64'd0);
        chk("mid_rst_level", 64'(bus.fifo_level), 64'd0);
        chk("mid_rst_data", 64'(bus.tx_data), 64'd0);
        bus.in_data = 48'hFEDCBA987654;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        recv(48'hFEDCBA987654, 1'b0, cyc);
        chk("fresh_end_valid", 64'(bus.tx_valid), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
